// File: rtl/ex_multu_unit.sv
// EX-stage unsigned multiplier: 32-step shift-add MULTU with HI/LO registers,
// MFHI/MFLO/MTHI/MTLO service and a hazard stall while a multiply is in flight.
module ex_multu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [5:0]  funct,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hilo_out,
  output logic        done
);

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [5:0]  count;
  logic [31:0] mcand;
  logic [63:0] p;
  logic [31:0] hi, lo;
  logic [32:0] sum;

  logic is_multu, is_mthi, is_mtlo, hilo_op;

  assign is_multu = en && (funct == F_MULTU);
  assign is_mthi  = en && (funct == F_MTHI);
  assign is_mtlo  = en && (funct == F_MTLO);
  assign hilo_op  = en && (funct == F_MULTU || funct == F_MFHI || funct == F_MFLO ||
                           funct == F_MTHI  || funct == F_MTLO);

  // 33-bit sum keeps the carry that becomes P[63] after the shift
  assign sum = {1'b0, p[63:32]} + {1'b0, (p[0] ? mcand : 32'd0)};

  assign busy     = (state != IDLE);
  assign stall    = busy && hilo_op;
  assign hilo_out = (funct == F_MFHI) ? hi : lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (is_multu) state_nx = BUSY;
      BUSY:    if (count == 6'd31) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      mcand <= '0;
      p     <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (is_multu) begin
            mcand <= RD1;
            p     <= {32'd0, RD2};
            count <= '0;
          end
          if (is_mthi) hi <= RD1;
          if (is_mtlo) lo <= RD1;
        end
        BUSY: begin
          p     <= {sum, p[31:1]};
          count <= count + 6'd1;
        end
        DONE: begin
          hi <= p[63:32];
          lo <= p[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_multu_unit.sv
// Bench for ex_multu_unit: directed scenarios plus a random instruction stream,
// checked against a cycle-level behavioural model of HI/LO and multiply timing.
module tb_ex_multu_unit;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk, rst, en;
  logic [5:0]  funct;
  logic [31:0] RD1, RD2;
  logic        busy, stall, done;
  logic [31:0] hilo_out;

  ex_multu_unit dut (
    .clk(clk), .rst(rst), .en(en), .funct(funct), .RD1(RD1), .RD2(RD2),
    .busy(busy), .stall(stall), .hilo_out(hilo_out), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: multiply issued in cycle t_iss is busy t_iss+1..t_iss+33, result visible t_iss+34
  int          cyc   = 0;
  int          t_iss = -1000;
  logic [63:0] prod  = '0;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;

  logic        stall_exp_l;
  logic        stall_obs_l;
  logic [31:0] hilo_l;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hilo_op(input logic [5:0] f);
    return f == F_MULTU || f == F_MFHI || f == F_MFLO || f == F_MTHI || f == F_MTLO;
  endfunction

  // one cycle: drive at posedge+1, check mid-cycle, advance model on the edge
  task automatic tick(input logic e, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic b_exp, s_exp;
    en = e; funct = f; RD1 = a; RD2 = b;
    #2;
    b_exp = (cyc >= t_iss + 1) && (cyc <= t_iss + 33);
    s_exp = b_exp && e && is_hilo_op(f);
    chk("busy", busy, b_exp);
    chk("stall", stall, s_exp);
    chk("done", done, (cyc == t_iss + 34));
    chk("hilo_out", hilo_out, (f == F_MFHI) ? m_hi : m_lo);
    stall_exp_l = s_exp;
    stall_obs_l = stall;
    hilo_l      = hilo_out;
    @(posedge clk); #1;
    if (b_exp && cyc == t_iss + 33) begin
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end
    if (!b_exp && e) begin
      if (f == F_MULTU) begin
        t_iss = cyc;
        prod  = {32'd0, a} * {32'd0, b};
      end
      if (f == F_MTHI) m_hi = a;
      if (f == F_MTLO) m_lo = a;
    end
    cyc++;
  endtask

  // issue one instruction, holding it in EX while the stall is up
  task automatic instr(input logic e, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, output int nst);
    int guard;
    nst = 0;
    guard = 0;
    tick(e, f, a, b);
    if (stall_obs_l) nst++;
    while (stall_exp_l && guard < 40) begin
      guard++;
      tick(e, f, a, b);
      if (stall_obs_l) nst++;
    end
    if (guard >= 40) chk("stall_bound", 64'(guard), 64'd0);
  endtask

  task automatic nops(input int n);
    int d;
    for (int i = 0; i < n; i++) instr(1'b0, 6'd0, $urandom, $urandom, d);
  endtask

  task automatic model_reset();
    t_iss = -1000;
    prod  = '0;
    m_hi  = '0;
    m_lo  = '0;
  endtask

  initial begin
    int ns;
    rst = 1'b0; en = 1'b0; funct = '0; RD1 = '0; RD2 = '0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hilo", hilo_out, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // 3 x 5
    instr(1'b1, F_MULTU, 32'd3, 32'd5, ns);
    nops(33);
    instr(1'b1, F_MFLO, '0, '0, ns);
    chk("lo_3x5", hilo_l, 32'h0000000F);
    instr(1'b1, F_MFHI, '0, '0, ns);
    chk("hi_3x5", hilo_l, 32'h00000000);

    // full-scale carry
    instr(1'b1, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, ns);
    nops(33);
    instr(1'b1, F_MFHI, '0, '0, ns);
    chk("hi_ffxff", hilo_l, 32'hFFFFFFFE);
    instr(1'b1, F_MFLO, '0, '0, ns);
    chk("lo_ffxff", hilo_l, 32'h00000001);

    // dependent MFHI right behind the multiply
    instr(1'b1, F_MULTU, 32'h80000000, 32'h00000002, ns);
    instr(1'b1, F_MFHI, '0, '0, ns);
    chk("stall_len", 64'(ns), 64'd33);
    chk("hi_8x2", hilo_l, 32'h00000001);
    instr(1'b1, F_MFLO, '0, '0, ns);
    chk("lo_8x2", hilo_l, 32'h00000000);

    // MTLO then MFLO in IDLE
    instr(1'b1, F_MTLO, 32'h12345678, '0, ns);
    instr(1'b1, F_MFLO, '0, '0, ns);
    chk("mtlo_rd", hilo_l, 32'h12345678);
    instr(1'b1, F_MFHI, '0, '0, ns);
    chk("hi_keep", hilo_l, 32'h00000001);

    // MTHI issued at T+5 waits out the multiply
    instr(1'b1, F_MULTU, 32'd7, 32'd6, ns);
    nops(4);
    instr(1'b1, F_MTHI, 32'hAAAA5555, '0, ns);
    chk("mthi_stall", 64'(ns), 64'd29);
    instr(1'b1, F_MFHI, '0, '0, ns);
    chk("mthi_hi", hilo_l, 32'hAAAA5555);
    instr(1'b1, F_MFLO, '0, '0, ns);
    chk("mthi_lo", hilo_l, 32'h0000002A);

    // asynchronous reset in the middle of a multiply
    instr(1'b1, F_MULTU, 32'd9, 32'd9, ns);
    nops(9);
    en = 1'b1; funct = F_MFHI; RD1 = '0; RD2 = '0;
    #1;
    chk("pre_rst_stall", stall, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_hilo", hilo_out, 32'd0);
    chk("arst_done", done, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cyc++;
    instr(1'b1, F_MULTU, 32'd2, 32'd2, ns);
    nops(33);
    instr(1'b1, F_MFLO, '0, '0, ns);
    chk("lo_2x2", hilo_l, 32'd4);

    // random instruction stream
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      logic        e;
      int          k;
      k = $urandom_range(0, 9);
      case (k)
        0:       f = F_MULTU;
        1, 2:    f = F_MFHI;
        3, 4:    f = F_MFLO;
        5:       f = F_MTHI;
        6:       f = F_MTLO;
        default: f = 6'($urandom_range(0, 63));
      endcase
      e = ($urandom_range(0, 4) != 0);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = '0;
        1: b = '0;
        2: a = 32'hFFFFFFFF;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      instr(e, f, a, b, ns);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
